// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state type and bus widths for the round-robin master arbiter.
package apb_pkg;
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; rotate by ptr, take lowest set bit, rotate back.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);
  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;
  assign w_rot = N'({req_i, req_i} >> ptr_i);
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) if (w_rot[i]) w_off = IW'(i);
  end
  assign any_o = |req_i;
  // offset is relative to ptr; fold back into 0..N-1 for non-power-of-two N
  assign w_sum = {1'b0, w_off} + {1'b0, ptr_i};
  assign idx_o = w_sum >= (IW + 1)'(N) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);
  assign grant_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: shares one APB master port among NUM_REQ requesters,
// round-robin, one transfer in flight, with a bounded ACCESS wait.
module apb_rr_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_write_i,
  input  logic [NUM_REQ*32-1:0]   req_addr_i,
  input  logic [NUM_REQ*32-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [APB_DW-1:0]       rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    apb_psel_o,
  output logic                    apb_penable_o,
  output logic [APB_AW-1:0]       apb_paddr_o,
  output logic                    apb_pwrite_o,
  output logic [APB_DW-1:0]       apb_pwdata_o,
  input  logic [APB_DW-1:0]       apb_prdata_i,
  input  logic                    apb_pready_i,
  input  logic                    apb_pslverr_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  apb_state_t          r_state, w_next;
  logic [IW-1:0]       r_ptr, r_owner, w_idx, w_ptr_nxt;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  w_grant, r_rsp_valid;
  logic                w_any, w_to, w_done, w_open, w_accept;
  logic [APB_AW-1:0]   r_paddr;
  logic [APB_DW-1:0]   r_pwdata, r_rdata;
  logic                r_pwrite, r_err, r_to;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_grant),
    .any_o   (w_any),
    .idx_o   (w_idx)
  );

  // pready on the last allowed cycle is a normal completion, never a timeout
  assign w_to      = r_state == ACCESS && !apb_pready_i && r_cnt == CW'(TIMEOUT_CYC - 1);
  assign w_done    = r_state == ACCESS && (apb_pready_i || w_to);
  assign w_open    = r_state == IDLE || w_done;
  assign w_accept  = w_open && w_any;
  assign w_ptr_nxt = w_idx == IW'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
  assign req_ready_o = (w_open && reset_n) ? w_grant : '0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb
    w_next = r_state == SETUP ? ACCESS : (w_accept ? SETUP : (w_done ? IDLE : r_state));

  always_comb begin
    apb_psel_o    = r_state != IDLE;
    apb_penable_o = r_state == ACCESS;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_to        <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
    end else begin
      r_cnt       <= (r_state == ACCESS && !apb_pready_i) ? r_cnt + 1'b1 : '0;
      r_rsp_valid <= w_done ? NUM_REQ'(1) << r_owner : '0;
      if (w_done) begin
        r_rdata <= (apb_pready_i && !r_pwrite) ? apb_prdata_i : '0;
        r_err   <= apb_pready_i ? apb_pslverr_i : 1'b1;
        r_to    <= !apb_pready_i;
      end
      if (w_accept) begin
        r_paddr  <= req_addr_i[APB_AW*w_idx +: APB_AW];
        r_pwdata <= req_wdata_i[APB_DW*w_idx +: APB_DW];
        r_pwrite <= req_write_i[w_idx];
        r_owner  <= w_idx;
        r_ptr    <= w_ptr_nxt;
      end
    end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_to;
  assign apb_paddr_o   = r_paddr;
  assign apb_pwrite_o  = r_pwrite;
  assign apb_pwdata_o  = r_pwdata;
endmodule
